// File: rtl/tpc_pkg.sv
// Shared types and sizing for the TPC warp dispatcher.
`include "define.sv"

package tpc_pkg;
  localparam int NUM_WARP       = `NUM_WARP;
  localparam int DEPTH_WARP     = `DEPTH_WARP;
  localparam int WCNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/define.sv
// Global warp sizing shared by the TPC blocks: warps per SM and warp-id width.
`ifndef TPC_DEFINE_SV
`define TPC_DEFINE_SV
`define NUM_WARP   16
`define DEPTH_WARP 4
`endif

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer and
// moves the pointer just past the winner whenever en is high and a grant is made.
module rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg, ptr_next;
  logic          found;
  int            idx;

  always_comb begin
    gnt      = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_reg) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_next = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (en && found) begin
      ptr_reg <= ptr_next;
    end
  end
endmodule

// File: rtl/tpc_warp_dispatch.sv
// Kernel warp dispatcher: spreads a kernel's warps over NUM_SM cores and counts completions.
// Optional response checking (sticky err_o, per-SM completion bitmaps) under TPC_RSP_CHECK_EN.
module tpc_warp_dispatch
  import tpc_pkg::*;
#(
  parameter int NUM_SM = 4,
  parameter int WCNT_W = WCNT_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         kernel_valid_i,
  output logic                         kernel_ready_o,
  input  logic [WCNT_W-1:0]            kernel_num_warps_i,
  output logic                         kernel_done_o,
  output logic                         busy_o,
  output logic [NUM_SM-1:0]            sm_req_valid_o,
  input  logic [NUM_SM-1:0]            sm_req_ready_i,
  input  logic [NUM_SM-1:0]            sm_rsp_valid_i,
  output logic [NUM_SM-1:0]            sm_rsp_ready_o,
  input  logic [NUM_SM*DEPTH_WARP-1:0] sm_rsp_wid_i,
  output logic                         err_o
);
  localparam int OW = DEPTH_WARP + 1;
  localparam int SW = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

  state_t                     state_reg, state_next;
  logic [WCNT_W-1:0]          num_warps_reg, issued_cnt_reg, done_cnt_reg;
  logic [NUM_SM-1:0]          req_gnt, rsp_gnt;
  logic [NUM_SM-1:0][OW-1:0]  outstanding;
  logic                       kernel_accept, dispatch_en, rsp_en;
  logic                       issue, rsp_fire, rsp_bad, rsp_count;

  always_comb begin
    state_next     = state_reg;
    kernel_ready_o = 1'b0;
    busy_o         = 1'b1;
    kernel_done_o  = 1'b0;
    dispatch_en    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        kernel_ready_o = 1'b1;
        busy_o         = 1'b0;
        if (kernel_valid_i)
          state_next = (kernel_num_warps_i == '0) ? ST_DONE : ST_DISPATCH;
      end
      ST_DISPATCH: begin
        // Requests stop as soon as the last warp is issued, one cycle before DRAIN.
        dispatch_en = (issued_cnt_reg != num_warps_reg);
        if (done_cnt_reg == num_warps_reg)
          state_next = ST_DONE;
        else if (issued_cnt_reg == num_warps_reg)
          state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (done_cnt_reg == num_warps_reg)
          state_next = ST_DONE;
      end
      ST_DONE: begin
        kernel_done_o = 1'b1;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign kernel_accept  = kernel_valid_i && kernel_ready_o;
  assign rsp_en         = (state_reg != ST_IDLE);
  assign sm_req_valid_o = dispatch_en ? req_gnt : '0;
  assign sm_rsp_ready_o = rsp_en ? rsp_gnt : '0;
  assign issue          = |(sm_req_valid_o & sm_req_ready_i);
  assign rsp_fire       = |(sm_rsp_ready_o & sm_rsp_valid_i);
  assign rsp_count      = rsp_fire && !rsp_bad;

  rr_arb #(.N(NUM_SM)) u_req_arb (
    .clk (clk),
    .rst (rst),
    .req (sm_req_ready_i),
    .en  (dispatch_en),
    .gnt (req_gnt)
  );

  rr_arb #(.N(NUM_SM)) u_rsp_arb (
    .clk (clk),
    .rst (rst),
    .req (sm_rsp_valid_i),
    .en  (rsp_en),
    .gnt (rsp_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      num_warps_reg  <= '0;
      issued_cnt_reg <= '0;
      done_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (kernel_accept) begin
        num_warps_reg  <= kernel_num_warps_i;
        issued_cnt_reg <= '0;
        done_cnt_reg   <= '0;
      end else begin
        if (issue)
          issued_cnt_reg <= issued_cnt_reg + WCNT_W'(1);
        if (rsp_count)
          done_cnt_reg <= done_cnt_reg + WCNT_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SM; gi++) begin : g_out
    logic [OW-1:0] cnt_reg;
    logic          inc, dec;

    assign inc = sm_req_valid_o[gi] && sm_req_ready_i[gi];
    assign dec = sm_rsp_ready_o[gi] && rsp_count;

    always_ff @(posedge clk) begin
      if (rst)
        cnt_reg <= '0;
      else if (inc && !dec)
        cnt_reg <= cnt_reg + OW'(1);
      else if (dec && !inc)
        cnt_reg <= cnt_reg - OW'(1);
    end

    assign outstanding[gi] = cnt_reg;
  end

`ifdef TPC_RSP_CHECK_EN
  logic [SW-1:0]         rsp_idx;
  logic [DEPTH_WARP-1:0] rsp_wid;
  logic [NUM_WARP-1:0]   seen_reg [NUM_SM];
  logic                  err_reg;

  always_comb begin
    rsp_idx = '0;
    for (int i = 0; i < NUM_SM; i++)
      if (rsp_gnt[i]) rsp_idx = SW'(i);
  end

  assign rsp_wid = sm_rsp_wid_i[rsp_idx*DEPTH_WARP +: DEPTH_WARP];
  // A bad response is still handshaked so the SM is never stalled, only left uncounted.
  assign rsp_bad = rsp_fire &&
                   ((outstanding[rsp_idx] == '0) || seen_reg[rsp_idx][rsp_wid]);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
      for (int i = 0; i < NUM_SM; i++) seen_reg[i] <= '0;
    end else begin
      if (rsp_bad)
        err_reg <= 1'b1;
      if (kernel_accept) begin
        for (int i = 0; i < NUM_SM; i++) seen_reg[i] <= '0;
      end else if (rsp_count) begin
        seen_reg[rsp_idx][rsp_wid] <= 1'b1;
      end
    end
  end

  assign err_o = err_reg;
`else
  logic unused_rsp;
  assign unused_rsp = ^{sm_rsp_wid_i, outstanding, SW'(0)};
  assign rsp_bad    = 1'b0;
  assign err_o      = 1'b0;
`endif
endmodule

// File: tb/tb_tpc_warp_dispatch.sv
// Scoreboard bench for tpc_warp_dispatch: expected grants are queued as stimulus is driven.
module tb_tpc_warp_dispatch;
  import tpc_pkg::*;

  localparam int NS = 4;
  localparam int WW = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     kernel_valid_i;
  logic                     kernel_ready_o;
  logic [WW-1:0]            kernel_num_warps_i;
  logic                     kernel_done_o;
  logic                     busy_o;
  logic [NS-1:0]            sm_req_valid_o;
  logic [NS-1:0]            sm_req_ready_i;
  logic [NS-1:0]            sm_rsp_valid_i;
  logic [NS-1:0]            sm_rsp_ready_o;
  logic [NS*DEPTH_WARP-1:0] sm_rsp_wid_i;
  logic                     err_o;

  always #5 clk = ~clk;

  tpc_warp_dispatch #(.NUM_SM(NS), .WCNT_W(WW)) dut (
    .clk                (clk),
    .rst                (rst),
    .kernel_valid_i     (kernel_valid_i),
    .kernel_ready_o     (kernel_ready_o),
    .kernel_num_warps_i (kernel_num_warps_i),
    .kernel_done_o      (kernel_done_o),
    .busy_o             (busy_o),
    .sm_req_valid_o     (sm_req_valid_o),
    .sm_req_ready_i     (sm_req_ready_i),
    .sm_rsp_valid_i     (sm_rsp_valid_i),
    .sm_rsp_ready_o     (sm_rsp_ready_o),
    .sm_rsp_wid_i       (sm_rsp_wid_i),
    .err_o              (err_o)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            done_pulses;
  int            req_ptr_m, rsp_ptr_m;
  int            rem [NS];
  int            wid_ctr [NS];
  logic [NS-1:0] exp_req_q [$];
  logic [NS-1:0] exp_rsp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [NS-1:0] m);
    for (int i = 0; i < NS; i++)
      if (m[(ptr + i) % NS]) return (ptr + i) % NS;
    return -1;
  endfunction

  task automatic expect_req(input logic [NS-1:0] m);
    logic [NS-1:0] one = 1;
    int g;
    g = rr_pick(req_ptr_m, m);
    if (g >= 0) begin
      exp_req_q.push_back(one << g);
      req_ptr_m = (g + 1) % NS;
      rem[g]++;
    end
  endtask

  task automatic expect_rsp(input logic [NS-1:0] m, output int g);
    logic [NS-1:0] one = 1;
    g = rr_pick(rsp_ptr_m, m);
    if (g >= 0) begin
      exp_rsp_q.push_back(one << g);
      rsp_ptr_m = (g + 1) % NS;
    end
  endtask

  // Sample this cycle's outputs, then advance to just after the next edge.
  task automatic tick();
    #1;
    if (sm_req_valid_o != '0) begin
      if (exp_req_q.size() == 0) check("req_unexpected", sm_req_valid_o, 0);
      else check("req_grant", sm_req_valid_o, exp_req_q.pop_front());
    end
    if (sm_rsp_ready_o != '0) begin
      if (exp_rsp_q.size() == 0) check("rsp_unexpected", sm_rsp_ready_o, 0);
      else check("rsp_grant", sm_rsp_ready_o, exp_rsp_q.pop_front());
    end
    if (kernel_done_o) done_pulses++;
    $display("t=%0t req=%b rsp=%b done=%b busy=%b", $time, sm_req_valid_o, sm_rsp_ready_o,
             kernel_done_o, busy_o);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    kernel_valid_i = 1'b0;
    kernel_num_warps_i = '0;
    sm_req_ready_i = '0;
    sm_rsp_valid_i = '0;
    sm_rsp_wid_i = '0;
    tick();
    tick();
    rst = 1'b0;
    req_ptr_m = 0;
    rsp_ptr_m = 0;
    for (int k = 0; k < NS; k++) begin rem[k] = 0; wid_ctr[k] = 0; end
    check("rst_ready", kernel_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", kernel_done_o, 0);
    check("rst_req_valid", sm_req_valid_o, 0);
    check("rst_rsp_ready", sm_rsp_ready_o, 0);
    check("rst_err", err_o, 0);
  endtask

  task automatic launch(input int n);
    kernel_valid_i = 1'b1;
    kernel_num_warps_i = WW'(n);
    for (int k = 0; k < NS; k++) wid_ctr[k] = 0;
    #1;
    check("launch_ready", kernel_ready_o, 1);
    tick();
    kernel_valid_i = 1'b0;
  endtask

  task automatic run_dispatch(input int n, input logic [NS-1:0] m);
    int issued_m = 0;
    for (int c = 0; c < 100 && issued_m < n; c++) begin
      sm_req_ready_i = m;
      if (m != '0) begin
        expect_req(m);
        issued_m++;
      end
      tick();
    end
    check("req_queue_empty", exp_req_q.size(), 0);
  endtask

  task automatic run_responses(input int n, input int base);
    logic [NS-1:0] v;
    int            g;
    int            got = 0;
    for (int c = 0; c < 100 && got < n; c++) begin
      for (int k = 0; k < NS; k++) begin
        v[k] = (rem[k] > 0);
        sm_rsp_wid_i[k*DEPTH_WARP +: DEPTH_WARP] = DEPTH_WARP'(wid_ctr[k]);
      end
      sm_rsp_valid_i = v;
      expect_rsp(v, g);
      tick();
      if (g >= 0) begin
        rem[g]--;
        wid_ctr[g]++;
        got++;
        check("done_cnt_step", dut.done_cnt_reg, base + got);
      end
    end
    sm_rsp_valid_i = '0;
    check("rsp_queue_empty", exp_rsp_q.size(), 0);
  endtask

  task automatic settle_done(input int exp_pulses);
    for (int c = 0; c < 4; c++) tick();
    check("done_pulses", done_pulses, exp_pulses);
    check("ready_after", kernel_ready_o, 1);
    check("busy_after", busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    kernel_valid_i = 1'b0;
    kernel_num_warps_i = '0;
    sm_req_ready_i = '0;
    sm_rsp_valid_i = '0;
    sm_rsp_wid_i = '0;
    done_pulses = 0;
    @(posedge clk);
    #1;
    reset_dut();

    // 8 warps over 4 ready SMs, then all responses
    done_pulses = 0;
    launch(8);
    run_dispatch(8, 4'hF);
    for (int k = 0; k < NS; k++) check("outstanding_8", dut.outstanding[k], 2);
    run_responses(8, 0);
    settle_done(1);

    // zero-warp kernel: done at T+1, ready at T+2, no requests
    done_pulses = 0;
    sm_req_ready_i = 4'hF;
    launch(0);
    check("zero_done_t1", kernel_done_o, 1);
    check("zero_no_req", sm_req_valid_o, 0);
    check("zero_not_ready_t1", kernel_ready_o, 0);
    tick();
    check("zero_ready_t2", kernel_ready_o, 1);
    check("zero_done_t2", kernel_done_o, 0);
    check("zero_pulses", done_pulses, 1);

    // only SM2 ready
    done_pulses = 0;
    launch(5);
    run_dispatch(5, 4'b0100);
    check("sm2_peak", dut.outstanding[2], 5);
    run_responses(5, 0);
    check("sm2_drained", dut.outstanding[2], 0);
    settle_done(1);

    // all four SMs respond in the same cycle
    done_pulses = 0;
    launch(4);
    run_dispatch(4, 4'hF);
    run_responses(4, 0);
    settle_done(1);

`ifdef TPC_RSP_CHECK_EN
    begin
      int g;
      done_pulses = 0;
      launch(2);
      run_dispatch(2, 4'b0001);
      sm_rsp_valid_i = 4'b0010;
      expect_rsp(4'b0010, g);
      tick();
      sm_rsp_valid_i = '0;
      check("err_set", err_o, 1);
      check("err_done_cnt", dut.done_cnt_reg, 0);
      run_responses(2, 0);
      settle_done(1);
      check("err_sticky", err_o, 1);
    end
`endif

    // reset in the middle of a 6-warp kernel
    done_pulses = 0;
    launch(6);
    run_dispatch(3, 4'hF);
    check("mid_issued", dut.issued_cnt_reg, 3);
    sm_req_ready_i = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_ptr_m = 0;
    rsp_ptr_m = 0;
    for (int k = 0; k < NS; k++) rem[k] = 0;
    check("mid_ready", kernel_ready_o, 1);
    check("mid_busy", busy_o, 0);
    check("mid_issued_clr", dut.issued_cnt_reg, 0);
    check("mid_done_clr", dut.done_cnt_reg, 0);
    check("mid_err_clr", err_o, 0);
    for (int k = 0; k < NS; k++) check("mid_out_clr", dut.outstanding[k], 0);
    settle_done(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tpc_warp_dispatch.md
TPC_WARP_DISPATCH -- requirements
Module: tpc_warp_dispatch

Interface
REQ-001 SHALL have parameter: NUM_SM, default 4, number of attached SM cores.
REQ-002 SHALL have parameter: WCNT_W, default 16, width of the kernel warp-count and progress counters.
REQ-003 SHALL have port: clk  in  1  system clock; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: rst  in  1  synchronous reset, active-high.
REQ-005 SHALL have port: kernel_valid_i  in  1  new kernel launch offered.
REQ-006 SHALL have port: kernel_ready_o  out  1  dispatcher can accept a kernel.
REQ-007 SHALL have port: kernel_num_warps_i  in  WCNT_W  total warps in the offered kernel.
REQ-008 SHALL have port: kernel_done_o  out  1  one-cycle pulse when all warps of the current kernel have completed.
REQ-009 SHALL have port: busy_o  out  1  kernel in progress.
REQ-010 SHALL have port: sm_req_valid_o  out  NUM_SM  per-SM warp-assign request, at most one bit set.
REQ-011 SHALL have port: sm_req_ready_i  in  NUM_SM  per-SM can take a warp.
REQ-012 SHALL have port: sm_rsp_valid_i  in  NUM_SM  per-SM completed-warp response.
REQ-013 SHALL have port: sm_rsp_ready_o  out  NUM_SM  per-SM response accept, at most one bit set.
REQ-014 SHALL have port: sm_rsp_wid_i  in  NUM_SM*DEPTH_WARP  per-SM completed warp id; slice k belongs to SM k.
REQ-015 SHALL have port: err_o  out  1  sticky protocol error (see Configuration).

Function
REQ-016 SHALL implement FSM states IDLE, DISPATCH, DRAIN, DONE.
REQ-017 SHALL assert kernel_ready_o only in IDLE; busy_o in DISPATCH, DRAIN, and DONE.
REQ-018 SHALL, on a kernel accept (valid&&ready) at cycle T, latch num_warps, clear issued_cnt/done_cnt, and enter DISPATCH at T+1.
REQ-019 SHALL, when kernel_num_warps_i==0, go IDLE->DONE and pulse kernel_done_o at T+1 with no SM requests.
REQ-020 SHALL, in DISPATCH, round-robin-grant one SM among sm_req_ready_i per cycle and drive sm_req_valid_o one-hot to it. Valid may depend on ready; SMs SHALL NOT make ready depend on valid.
REQ-021 SHALL count an issue as sm_req_valid_o[k]&&sm_req_ready_i[k], incrementing issued_cnt and outstanding[k].
REQ-022 SHALL move DISPATCH->DRAIN the cycle after issued_cnt reaches num_warps, and drive no requests in DRAIN, DONE, or IDLE.
REQ-023 SHALL accept responses in every non-IDLE state via an independent round-robin grant among sm_rsp_valid_i, one per cycle, with sm_rsp_ready_o one-hot. Each accept increments done_cnt and decrements outstanding[k].
REQ-024 SHALL leave outstanding[k] unchanged on a same-cycle issue and response for SM k; outstanding counters are DEPTH_WARP+1 bits.
REQ-025 SHALL enter DONE the cycle after done_cnt reaches num_warps (from DRAIN, or from DISPATCH if the last issue and last response coincide), pulse kernel_done_o for exactly one cycle, then return to IDLE.
REQ-026 SHALL hold both arbiter pointers across kernels (no pointer reset at kernel start).
REQ-027 SHALL hold sm_rsp_ready_o at 0 in IDLE.

Reset
REQ-028 SHALL on rst return to IDLE, clear all counters, outstanding[], err_o, and arbiter pointers; outputs: kernel_ready_o=1, busy_o=0, kernel_done_o=0, sm_req_valid_o=0, sm_rsp_ready_o=0.
REQ-029 SHALL abandon any in-flight kernel on rst mid-operation and not report it as done.

Configuration
REQ-030 SHALL, with TPC_RSP_CHECK_EN defined, set err_o sticky when a response is accepted from SM k with outstanding[k]==0, or a response wid is already marked completed in that SM's per-warp bitmap; the offending response is still accepted but not counted.
REQ-031 SHALL, without TPC_RSP_CHECK_EN, tie err_o to 0, omit the bitmaps, and count every accepted response.

Structure
REQ-032 SHALL place the FSM state enum typedef and WCNT_W default in shared package tpc_pkg; NUM_WARP/DEPTH_WARP come from define.sv.
REQ-033 SHALL reuse the existing rr_arb sub-module, instantiated twice (request grant and response grant).

Verification
REQ-034 SHALL cover: num_warps=8, all 4 SMs ready -> 8 issues one per cycle rotating SM0..3,0..3; after 8 responses, kernel_done_o pulses once.
REQ-035 SHALL cover: num_warps=0 -> no sm_req_valid_o; kernel_done_o at T+1; kernel_ready_o back high at T+2.
REQ-036 SHALL cover: only SM2 ready -> all 5 warps go to SM2; outstanding[2] peaks at 5 and returns to 0.
REQ-037 SHALL cover: all 4 SMs assert rsp_valid in the same cycle -> accepts over 4 consecutive cycles in round-robin order; done_cnt +1 per cycle.
REQ-038 SHALL cover: rst asserted with issued=3 of 6 -> next cycle IDLE, counters 0, no done pulse.
REQ-039 SHALL cover, with TPC_RSP_CHECK_EN: response from SM1 with outstanding[1]=0 -> err_o=1 and stays 1 until rst; done_cnt unchanged.
